// File: rtl/controlador_entrada_saida_if.sv
// -----------------------------------------------------------------------------
// controlador_entrada_saida_if
//
// Groups the opcode/board/register-bank signals of the I/O controller.
//   slave  : seen from the controller (inputs opcode, switches, botao_confirma,
//            dado_saida; outputs dado_entrada, escrita_entrada, pc_stall,
//            display_valor, display_valido, led_aguardando[, erro_timeout]).
//   master : seen from the surrounding processor/board (directions reversed).
//
// Parameter DATA_W sets the switch bus width.
// Optional macro ES_TIMEOUT_EN adds the erro_timeout signal.
// -----------------------------------------------------------------------------
interface controlador_entrada_saida_if #(
  parameter int DATA_W = 16
);
  logic [4:0]        opcode;
  logic [DATA_W-1:0] switches;
  logic              botao_confirma;
  logic [31:0]       dado_saida;
  logic [31:0]       dado_entrada;
  logic              escrita_entrada;
  logic              pc_stall;
  logic [31:0]       display_valor;
  logic              display_valido;
  logic              led_aguardando;

`ifdef ES_TIMEOUT_EN
  logic              erro_timeout;

  modport slave (
    input  opcode, switches, botao_confirma, dado_saida,
    output dado_entrada, escrita_entrada, pc_stall,
    output display_valor, display_valido, led_aguardando, erro_timeout
  );

  modport master (
    output opcode, switches, botao_confirma, dado_saida,
    input  dado_entrada, escrita_entrada, pc_stall,
    input  display_valor, display_valido, led_aguardando, erro_timeout
  );
`else
  modport slave (
    input  opcode, switches, botao_confirma, dado_saida,
    output dado_entrada, escrita_entrada, pc_stall,
    output display_valor, display_valido, led_aguardando
  );

  modport master (
    output opcode, switches, botao_confirma, dado_saida,
    input  dado_entrada, escrita_entrada, pc_stall,
    input  display_valor, display_valido, led_aguardando
  );
`endif
endinterface

// File: rtl/controlador_entrada_saida.sv
// -----------------------------------------------------------------------------
// controlador_entrada_saida
//
// I/O controller for the single-cycle processor.
//   - `in`  (opcode 19): stalls the PC, waits for the confirm button to be seen
//     released and then pressed (both debounced), captures the switches and
//     issues a one-cycle register-bank write.
//   - `out` (opcode 20): registers the register-bank value for the display.
//
// Ports:
//   clock  : system clock, rising edge
//   reset  : synchronous, active-high
//   io     : controlador_entrada_saida_if.slave
//              opcode, switches, botao_confirma (raw async), dado_saida in;
//              dado_entrada, escrita_entrada, pc_stall, display_valor,
//              display_valido, led_aguardando out.
//
// Parameters:
//   DATA_W          : switch width, captured value zero-extended to 32 bits
//   DEBOUNCE_CYCLES : consecutive stable cycles that qualify a button level (>=1)
//
// Optional feature (macro ES_TIMEOUT_EN): adds TIMEOUT_CYCLES and erro_timeout.
// When the controller has waited TIMEOUT_CYCLES cycles for the button it writes
// 0 to the register bank and raises erro_timeout until reset. Without the macro
// the controller waits indefinitely.
// -----------------------------------------------------------------------------
module controlador_entrada_saida #(
  parameter int DATA_W          = 16,
  parameter int DEBOUNCE_CYCLES = 50000
`ifdef ES_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES  = 500_000_000
`endif
) (
  input  logic                       clock,
  input  logic                       reset,
  controlador_entrada_saida_if.slave io
);

  localparam logic [4:0] OPCODE_IN  = 5'd19;
  localparam logic [4:0] OPCODE_OUT = 5'd20;

  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

`ifdef ES_TIMEOUT_EN
  localparam int               TMR_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TIMER_MAX = TMR_W'(TIMEOUT_CYCLES);
`endif

  typedef enum logic [1:0] {
    OCIOSO,
    ESPERA_SOLTA,
    ESPERA_APERTO,
    CAPTURA
  } estado_t;

  estado_t           estado;
  estado_t           estadoProx;
  logic [CNT_W-1:0]  contador;
  logic [CNT_W-1:0]  contadorProx;
  logic [CNT_W-1:0]  contadorInc;
  logic [31:0]       dadoEntrada;
  logic [DATA_W-1:0] switchesAmostra;
  logic              capturar;
  logic              ehInstrEntrada;
  logic              emEspera;
  logic              botaoMeta;
  logic              btnSync;
  logic [31:0]       displayValor;
  logic              displayValido;

`ifdef ES_TIMEOUT_EN
  logic [TMR_W-1:0]  timer;
  logic [TMR_W-1:0]  timerProx;
  logic              disparaTimeout;
  logic              erroTimeout;
`endif

  assign ehInstrEntrada  = (io.opcode == OPCODE_IN);
  assign emEspera        = (estado == ESPERA_SOLTA) || (estado == ESPERA_APERTO);
  assign switchesAmostra = io.switches;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser for the asynchronous push-button.
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments make each flop sample the value from before
  // the edge; blocking ones would collapse the chain into a single flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      botaoMeta <= 1'b0;
      btnSync   <= 1'b0;
    end else begin
      botaoMeta <= io.botao_confirma;
      btnSync   <= botaoMeta;
    end
  end

  // Saturating increment: the counter never wraps even if left counting.
  assign contadorInc = (contador == CNT_MAX) ? CNT_MAX : contador + CNT_W'(1);

`ifdef ES_TIMEOUT_EN
  // Only compared against TIMER_MAX, and the FSM leaves the wait on that edge,
  // so no saturation is needed.
  logic [TMR_W-1:0] timerInc;
  assign timerInc = timer + TMR_W'(1);
`endif

  // ---------------------------------------------------------------------------
  // FSM next state. The debounce counter tracks the length of the current run
  // of the level being waited for; any opposite sample restarts it, so a
  // glitch never changes state.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // one unassigned, which would otherwise infer a latch.
    estadoProx   = estado;
    contadorProx = contador;
    capturar     = 1'b0;
`ifdef ES_TIMEOUT_EN
    timerProx      = '0;
    disparaTimeout = 1'b0;
`endif

    case (estado)
      OCIOSO: begin
        if (ehInstrEntrada) begin
          estadoProx   = ESPERA_SOLTA;
          contadorProx = '0;
        end
      end

      // The button must first be seen released, so a press left over from a
      // previous `in` cannot satisfy this one.
      ESPERA_SOLTA: begin
        if (!ehInstrEntrada) begin
          estadoProx   = OCIOSO;
          contadorProx = '0;
        end else if (btnSync) begin
          contadorProx = '0;
        end else if (contadorInc == CNT_MAX) begin
          estadoProx   = ESPERA_APERTO;
          contadorProx = '0;
        end else begin
          contadorProx = contadorInc;
        end
      end

      ESPERA_APERTO: begin
        if (!ehInstrEntrada) begin
          estadoProx   = OCIOSO;
          contadorProx = '0;
        end else if (!btnSync) begin
          contadorProx = '0;
        end else if (contadorInc == CNT_MAX) begin
          estadoProx   = CAPTURA;
          contadorProx = '0;
          capturar     = 1'b1;
        end else begin
          contadorProx = contadorInc;
        end
      end

      CAPTURA: begin
        estadoProx = OCIOSO;
      end

      default: begin
        estadoProx   = OCIOSO;
        contadorProx = '0;
      end
    endcase

`ifdef ES_TIMEOUT_EN
    // The timer runs only while waiting for a legitimate `in`; expiry wins
    // over a coincident capture and turns it into a write of 0.
    if (emEspera && ehInstrEntrada) begin
      timerProx = timerInc;
      if (timerInc == TIMER_MAX) begin
        estadoProx     = CAPTURA;
        contadorProx   = '0;
        capturar       = 1'b0;
        disparaTimeout = 1'b1;
      end
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // FSM state, debounce counter and captured value.
  // dadoEntrada only changes on entry to CAPTURA, so it stays stable from the
  // write pulse until the next capture.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      estado      <= OCIOSO;
      contador    <= '0;
      dadoEntrada <= '0;
    end else begin
      estado   <= estadoProx;
      contador <= contadorProx;
      if (capturar) begin
        dadoEntrada <= 32'(switchesAmostra);
      end
`ifdef ES_TIMEOUT_EN
      else if (disparaTimeout) begin
        dadoEntrada <= '0;
      end
`endif
    end
  end

`ifdef ES_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      timer       <= '0;
      erroTimeout <= 1'b0;
    end else begin
      timer <= timerProx;
      if (disparaTimeout) begin
        erroTimeout <= 1'b1;
      end
    end
  end

  assign io.erro_timeout = erroTimeout;
`endif

  // ---------------------------------------------------------------------------
  // `out` path: independent of the FSM, samples every cycle with opcode 20.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      displayValor  <= '0;
      displayValido <= 1'b0;
    end else if (io.opcode == OPCODE_OUT) begin
      displayValor  <= io.dado_saida;
      displayValido <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. The combinational ones are gated by reset so they read 0 during
  // the reset cycle regardless of the state still held in the registers.
  // pc_stall falls in the CAPTURA cycle, together with the write pulse, so the
  // bank write and the PC advance share one edge.
  // ---------------------------------------------------------------------------
  assign io.dado_entrada    = dadoEntrada;
  assign io.escrita_entrada = !reset && (estado == CAPTURA);
  assign io.pc_stall        = !reset && ehInstrEntrada && (estado != CAPTURA);
  assign io.led_aguardando  = !reset && emEspera;
  assign io.display_valor   = displayValor;
  assign io.display_valido  = displayValido;

endmodule

// File: tb/tb_controlador_entrada_saida.sv
// -----------------------------------------------------------------------------
// tb_controlador_entrada_saida
//
// Bench for controlador_entrada_saida with DEBOUNCE_CYCLES=4, DATA_W=16.
// A vector table covers reset and the `out` path; hand-written episodes cover
// the basic `in`, a held button, bounce and reset mid-press; random button
// waveforms are checked against a window-search model of the handshake.
// With ES_TIMEOUT_EN a second instance (TIMEOUT_CYCLES=20) checks the timeout.
// -----------------------------------------------------------------------------
module tb_controlador_entrada_saida;

  localparam int DEB   = 4;
  localparam int MAXC  = 64;
  localparam int LIMIT = 50;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  controlador_entrada_saida_if #(.DATA_W(16)) io ();

  controlador_entrada_saida #(
    .DATA_W(16),
    .DEBOUNCE_CYCLES(DEB)
`ifdef ES_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(1000)
`endif
  ) dut (
    .clock(clock),
    .reset(reset),
    .io(io)
  );

`ifdef ES_TIMEOUT_EN
  controlador_entrada_saida_if #(.DATA_W(16)) ioT ();

  controlador_entrada_saida #(
    .DATA_W(16),
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES(20)
  ) dutT (
    .clock(clock),
    .reset(reset),
    .io(ioT)
  );
`endif

  int          vectors    = 0;
  int          miscompares = 0;
  logic [31:0] expDado    = '0;
  logic [31:0] expValor   = '0;
  logic        expValido  = 1'b0;

  // Raw button level per cycle of an episode; index k holds the level during
  // cycle k-2, i.e. the level the FSM sees (after synchronisation) at edge k+1.
  bit          rawArr [0:MAXC+2];

  typedef struct {
    logic        rst;
    logic [4:0]  op;
    logic [31:0] dado;
    logic        expStall;
    logic [31:0] expValor;
    logic        expValido;
  } vec_t;

  vec_t tab [10];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Handshake model: the release is the first run of DEB low samples seen
  // after entering the wait; the capture is the first run of DEB high samples
  // lying entirely after it. Returns the edge (1 = edge that starts the wait)
  // on which the write pulse appears, or -1 if none within limit edges.
  function automatic int predictCapture(int limit);
    int  relEnd;
    bit  all;
    relEnd = -1;
    for (int i = DEB; i < limit; i++) begin
      all = 1'b1;
      for (int k = 0; k < DEB; k++) if (rawArr[i-k]) all = 1'b0;
      if (all) begin
        relEnd = i;
        break;
      end
    end
    if (relEnd < 0) return -1;
    for (int j = relEnd + DEB; j + 1 <= limit; j++) begin
      all = 1'b1;
      for (int k = 0; k < DEB; k++) if (!rawArr[j-k]) all = 1'b0;
      if (all) return j + 1;
    end
    return -1;
  endfunction

  // Runs one `in` using rawArr; expE is the expected write edge or -1.
  task automatic runEpisode(string name, logic [15:0] sw, int expE, int limit);
    bit done;
    done = 1'b0;
    io.switches = sw;
    io.opcode   = 5'd0;
    for (int k = 0; k < 2; k++) begin
      io.botao_confirma = rawArr[k];
      tick();
    end
    for (int c = 0; c < limit; c++) begin
      io.opcode         = 5'd19;
      io.botao_confirma = rawArr[c+2];
      tick();
      if (c + 1 == expE) begin
        expDado = {16'h0, sw};
        check({name, " write"}, 32'(io.escrita_entrada), 1);
        check({name, " data"}, io.dado_entrada, expDado);
        check({name, " stall at write"}, 32'(io.pc_stall), 0);
        check({name, " led at write"}, 32'(io.led_aguardando), 0);
        io.opcode = 5'd0;
        tick();
        check({name, " pulse width"}, 32'(io.escrita_entrada), 0);
        check({name, " data hold"}, io.dado_entrada, expDado);
        done = 1'b1;
        break;
      end else begin
        check({name, " no write"}, 32'(io.escrita_entrada), 0);
        check({name, " stall"}, 32'(io.pc_stall), 1);
        check({name, " led"}, 32'(io.led_aguardando), 1);
      end
    end
    if (!done) begin
      io.opcode = 5'd0;
      tick();
      check({name, " abort led"}, 32'(io.led_aguardando), 0);
      check({name, " abort no write"}, 32'(io.escrita_entrada), 0);
      check({name, " abort data"}, io.dado_entrada, expDado);
    end
  endtask

  initial begin
    logic [31:0] d;
    int          idx;
    int          len;
    bit          lvl;
    int          e;
`ifdef ES_TIMEOUT_EN
    int          found;
`endif

    reset             = 1'b1;
    io.opcode         = 5'd0;
    io.switches       = 16'h0;
    io.botao_confirma = 1'b0;
    io.dado_saida     = 32'h0;
`ifdef ES_TIMEOUT_EN
    ioT.opcode         = 5'd0;
    ioT.switches       = 16'h0;
    ioT.botao_confirma = 1'b0;
    ioT.dado_saida     = 32'h0;
`endif

    // ---- vector table: reset state and the `out` path ----
    tab[0] = '{1'b1, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0};
    tab[1] = '{1'b0, 5'd0,  32'h11,       1'b0, 32'h0,        1'b0};
    tab[2] = '{1'b0, 5'd20, 32'd1234,     1'b0, 32'd1234,     1'b1};
    tab[3] = '{1'b0, 5'd0,  32'h999,      1'b0, 32'd1234,     1'b1};
    tab[4] = '{1'b0, 5'd20, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b1};
    tab[5] = '{1'b0, 5'd5,  32'h7,        1'b0, 32'hDEADBEEF, 1'b1};
    tab[6] = '{1'b1, 5'd19, 32'h0,        1'b0, 32'h0,        1'b0};
    tab[7] = '{1'b1, 5'd20, 32'd42,       1'b0, 32'h0,        1'b0};
    tab[8] = '{1'b0, 5'd20, 32'd42,       1'b0, 32'd42,       1'b1};
    tab[9] = '{1'b0, 5'd21, 32'h3,        1'b0, 32'd42,       1'b1};

    for (int i = 0; i < 10; i++) begin
      reset         = tab[i].rst;
      io.opcode     = tab[i].op;
      io.dado_saida = tab[i].dado;
      #1;
      check($sformatf("tab%0d stall", i), 32'(io.pc_stall), 32'(tab[i].expStall));
      tick();
      check($sformatf("tab%0d display_valor", i), io.display_valor, tab[i].expValor);
      check($sformatf("tab%0d display_valido", i), 32'(io.display_valido), 32'(tab[i].expValido));
      check($sformatf("tab%0d led", i), 32'(io.led_aguardando), 0);
      check($sformatf("tab%0d write", i), 32'(io.escrita_entrada), 0);
      check($sformatf("tab%0d dado_entrada", i), io.dado_entrada, expDado);
    end
    reset     = 1'b0;
    expValor  = 32'd42;
    expValido = 1'b1;

    // ---- basic `in`: release held from start, press after 8 cycles ----
    for (int k = 0; k <= MAXC + 2; k++) rawArr[k] = (k >= 10);
    runEpisode("basic", 16'hA5A5, 14, LIMIT);

    // ---- button held when `in` starts: release then press needed ----
    for (int k = 0; k <= MAXC + 2; k++) rawArr[k] = !(k >= 12 && k <= 16);
    runEpisode("held", 16'h3C3C, 21, LIMIT);

    // ---- bounce 1,1,0,1,1,1,0 before a clean press ----
    for (int k = 0; k <= MAXC + 2; k++) rawArr[k] = (k >= 15);
    rawArr[8]  = 1'b1; rawArr[9]  = 1'b1; rawArr[10] = 1'b0;
    rawArr[11] = 1'b1; rawArr[12] = 1'b1; rawArr[13] = 1'b1;
    rawArr[14] = 1'b0;
    runEpisode("bounce", 16'h0F0F, 19, LIMIT);

    // ---- random episodes against the model, each preceded by an `out` ----
    for (int ep = 0; ep < 24; ep++) begin
      d             = $urandom;
      io.opcode     = 5'd20;
      io.dado_saida = d;
      tick();
      expValor  = d;
      expValido = 1'b1;
      check("rnd display_valor", io.display_valor, expValor);
      check("rnd display_valido", 32'(io.display_valido), 32'(expValido));

      idx = 0;
      lvl = 1'($urandom_range(0, 1));
      while (idx <= MAXC + 2) begin
        len = int'($urandom_range(1, 7));
        for (int k = 0; k < len && idx <= MAXC + 2; k++) begin
          rawArr[idx] = lvl;
          idx++;
        end
        lvl = ~lvl;
      end
      e = predictCapture(LIMIT);
      runEpisode($sformatf("rnd%0d", ep), 16'($urandom), e, LIMIT);
      check("rnd display hold", io.display_valor, expValor);
    end

    // ---- reset in ESPERA_APERTO: no pulse, all outputs cleared ----
    io.switches       = 16'h1357;
    io.opcode         = 5'd0;
    io.botao_confirma = 1'b0;
    tick();
    tick();
    io.opcode = 5'd19;
    for (int c = 0; c < 9; c++) begin
      io.botao_confirma = (c >= 5);
      tick();
      check("rst-pre no write", 32'(io.escrita_entrada), 0);
      check("rst-pre led", 32'(io.led_aguardando), 1);
    end
    reset = 1'b1;
    #1;
    check("rst stall during reset", 32'(io.pc_stall), 0);
    check("rst led during reset", 32'(io.led_aguardando), 0);
    tick();
    expDado   = '0;
    expValor  = '0;
    expValido = 1'b0;
    check("rst dado_entrada", io.dado_entrada, expDado);
    check("rst display_valor", io.display_valor, expValor);
    check("rst display_valido", 32'(io.display_valido), 0);
    check("rst write", 32'(io.escrita_entrada), 0);
    check("rst led", 32'(io.led_aguardando), 0);
    reset = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      check("post-rst no write", 32'(io.escrita_entrada), 0);
      check("post-rst stall", 32'(io.pc_stall), 1);
    end
    io.opcode = 5'd0;
    tick();
    check("post-rst idle led", 32'(io.led_aguardando), 0);
    check("post-rst dado_entrada", io.dado_entrada, expDado);

`ifdef ES_TIMEOUT_EN
    // ---- timeout: no press, write of 0 and sticky error ----
    ioT.switches       = 16'hFFFF;
    ioT.botao_confirma = 1'b0;
    ioT.opcode         = 5'd19;
    found = -1;
    for (int k = 1; k <= 40 && found < 0; k++) begin
      tick();
      if (ioT.escrita_entrada) begin
        found = k;
        check("timeout data", ioT.dado_entrada, 32'h0);
        check("timeout error", 32'(ioT.erro_timeout), 1);
      end
    end
    check("timeout edge", 32'(found), 32'd21);
    ioT.opcode = 5'd0;
    repeat (5) tick();
    check("timeout sticky", 32'(ioT.erro_timeout), 1);
    reset = 1'b1;
    tick();
    check("timeout cleared", 32'(ioT.erro_timeout), 0);
    reset = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
